pdp8ltc08brk: RTL

PDP8LTC08BRK -- requirements
Module: pdp8ltc08brk

---
 rtl/pdp8ltc08brk.sv | 198 +++++++++++++++++++
 1 files changed

// File: rtl/pdp8ltc08brk.sv
// pdp8ltc08brk: TC08 DECtape three-cycle data-break engine behind a four-register ARM window.
// Define TC08BRK_COUNT_EN to provide the completed-break counter at register 2.
module pdp8ltc08brk (
    input  logic        CLOCK,
    input  logic        RESET,
    input  logic        armwrite,
    input  logic [1:0]  armraddr,
    input  logic [1:0]  armwaddr,
    input  logic [31:0] armwdata,
    output logic [31:0] armrdata,
    output logic        brkrq,
    output logic [14:0] brkaddr,
    output logic        brkwrite,
    output logic [11:0] brkwdata,
    input  logic        brkack,
    input  logic [11:0] brkrdata
);

    localparam logic [2:0]  IDLE    = 3'd0;
    localparam logic [2:0]  WCRD    = 3'd1;
    localparam logic [2:0]  WCWR    = 3'd2;
    localparam logic [2:0]  CARD    = 3'd3;
    localparam logic [2:0]  CAWR    = 3'd4;
    localparam logic [2:0]  DATA    = 3'd5;
    localparam logic [31:0] ID_WORD = 32'h5442_0002;
    localparam logic [14:0] WC_ADDR = 15'o07754;
    localparam logic [14:0] CA_ADDR = 15'o07755;

    logic [2:0]  state_r;
    logic [2:0]  state_nxt_s;
    logic        enable_r;
    logic        dir_r;
    logic [2:0]  field_r;
    logic        done_r;
    logic        wcovf_r;
    logic [11:0] data_r;
    logic [11:0] wc_r;
    logic [11:0] ca_r;
    logic        brkrq_r;
    logic [14:0] brkaddr_r;
    logic        brkwrite_r;
    logic [11:0] brkwdata_r;
    logic [14:0] req_addr_s;
    logic        req_write_s;
    logic [11:0] req_wdata_s;
    logic [31:0] count_s;
    logic        busy_s;
    logic        reg1_wr_s;
    logic        start_s;
    logic        ack_s;
    logic        issue_s;
    logic        unused_s;

    assign busy_s    = (state_r != IDLE);
    assign reg1_wr_s = armwrite && (armwaddr == 2'd1) && !busy_s;
    // Start is qualified by the enable bit of the same write, so one write can enable and start.
    assign start_s   = reg1_wr_s && armwdata[31] && armwdata[29];
    assign ack_s     = brkrq_r && brkack;
    // A request goes out one cycle after each state is entered, giving a low cycle between breaks.
    assign issue_s   = busy_s && !brkrq_r;
    assign unused_s  = ^{armwdata[30], armwdata[28], armwdata[23:12]};

    assign brkrq    = brkrq_r;
    assign brkaddr  = brkaddr_r;
    assign brkwrite = brkwrite_r;
    assign brkwdata = brkwdata_r;

    // Next-state and memory request selection for the break sequence.
    always_comb begin
        state_nxt_s = state_r;
        req_addr_s  = 15'd0;
        req_write_s = 1'b0;
        req_wdata_s = 12'd0;
        case (state_r)
            IDLE: begin
                if (start_s) state_nxt_s = WCRD;
                else         state_nxt_s = IDLE;
            end
            WCRD: begin
                req_addr_s = WC_ADDR;
                if (ack_s) state_nxt_s = WCWR;
                else       state_nxt_s = WCRD;
            end
            WCWR: begin
                req_addr_s  = WC_ADDR;
                req_write_s = 1'b1;
                req_wdata_s = wc_r;
                if (ack_s) state_nxt_s = CARD;
                else       state_nxt_s = WCWR;
            end
            CARD: begin
                req_addr_s = CA_ADDR;
                if (ack_s) state_nxt_s = CAWR;
                else       state_nxt_s = CARD;
            end
            CAWR: begin
                req_addr_s  = CA_ADDR;
                req_write_s = 1'b1;
                req_wdata_s = ca_r;
                if (ack_s) state_nxt_s = DATA;
                else       state_nxt_s = CAWR;
            end
            DATA: begin
                req_addr_s  = {field_r, ca_r};
                req_write_s = dir_r;
                req_wdata_s = data_r;
                if (ack_s) state_nxt_s = IDLE;
                else       state_nxt_s = DATA;
            end
            default: state_nxt_s = IDLE;
        endcase
    end

    // Control register, break sequencer and memory request registers.
    always_ff @(posedge CLOCK) begin
        if (RESET) begin
            state_r    <= IDLE;
            enable_r   <= 1'b0;
            dir_r      <= 1'b0;
            field_r    <= 3'd0;
            done_r     <= 1'b0;
            wcovf_r    <= 1'b0;
            data_r     <= 12'd0;
            wc_r       <= 12'd0;
            ca_r       <= 12'd0;
            brkrq_r    <= 1'b0;
            brkaddr_r  <= 15'd0;
            brkwrite_r <= 1'b0;
            brkwdata_r <= 12'd0;
        end else begin
            state_r <= state_nxt_s;
            if (issue_s) begin
                brkrq_r    <= 1'b1;
                brkaddr_r  <= req_addr_s;
                brkwrite_r <= req_write_s;
                brkwdata_r <= req_wdata_s;
            end else if (ack_s) begin
                brkrq_r <= 1'b0;
            end
            if (reg1_wr_s) begin
                enable_r <= armwdata[31];
                dir_r    <= armwdata[27];
                field_r  <= armwdata[26:24];
                data_r   <= armwdata[11:0];
                if (start_s) begin
                    done_r  <= 1'b0;
                    wcovf_r <= 1'b0;
                end
            end
            // Read values are stored pre-incremented; the write cycles reuse them directly.
            if (ack_s) begin
                case (state_r)
                    WCRD: wc_r <= brkrdata + 12'd1;
                    WCWR: wcovf_r <= (wc_r == 12'd0);
                    CARD: ca_r <= brkrdata + 12'd1;
                    DATA: begin
                        done_r <= 1'b1;
                        if (!dir_r) data_r <= brkrdata;
                    end
                    default: wc_r <= wc_r;
                endcase
            end
        end
    end

`ifdef TC08BRK_COUNT_EN
    logic [31:0] count_r;

    // Completed-break counter; a write to register 2 clears it.
    always_ff @(posedge CLOCK) begin
        if (RESET) begin
            count_r <= 32'd0;
        end else if (armwrite && (armwaddr == 2'd2)) begin
            count_r <= 32'd0;
        end else if (ack_s && (state_r == DATA)) begin
            count_r <= count_r + 32'd1;
        end
    end

    assign count_s = count_r;
`else
    assign count_s = 32'd0;
`endif

    // Register read mux.
    always_comb begin
        armrdata = 32'd0;
        case (armraddr)
            2'd0:    armrdata = ID_WORD;
            2'd1:    armrdata = {enable_r, busy_s, 1'b0, wcovf_r, dir_r, field_r, done_r,
                                 11'd0, data_r};
            2'd2:    armrdata = count_s;
            2'd3:    armrdata = 32'd0;
            default: armrdata = 32'd0;
        endcase
    end

endmodule
